// File: rtl/ppd_pkg.sv
// Shared constants, FSM states and saturation helpers
// for the polyphase decimator MAC engine.
package ppd_pkg;

  localparam int NUM_PHASE = 4;
  localparam int NUM_GROUP = 5;
  localparam int COEF_W    = 11;
  localparam int GRP_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/ppd_poly_mac_if.sv
// Frame-in / result-out handshake bundle of ppd_poly_mac.
// slave = engine side, master = upstream/downstream side.
// dout_o is DATA_W wide when PPD_MAC_ROUND_EN is defined,
// otherwise ACC_W wide.
interface ppd_poly_mac_if #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 28
);

`ifdef PPD_MAC_ROUND_EN
  localparam int OUT_W = DATA_W;
`else
  localparam int OUT_W = ACC_W;
`endif

  logic                     in_valid_i;
  logic                     in_ready_o;
  logic signed [DATA_W-1:0] din_p1_i;
  logic signed [DATA_W-1:0] din_p2_i;
  logic signed [DATA_W-1:0] din_p3_i;
  logic signed [DATA_W-1:0] din_p4_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic signed [OUT_W-1:0]  dout_o;

  modport slave (
    input  in_valid_i,
    input  din_p1_i,
    input  din_p2_i,
    input  din_p3_i,
    input  din_p4_i,
    output in_ready_o,
    output out_valid_o,
    input  out_ready_i,
    output dout_o
  );

  modport master (
    output in_valid_i,
    output din_p1_i,
    output din_p2_i,
    output din_p3_i,
    output din_p4_i,
    input  in_ready_o,
    input  out_valid_o,
    output out_ready_i,
    input  dout_o
  );

endinterface

// File: rtl/ppd_branch_sum.sv
// One coefficient group: 4 signed products summed into ACC_W.
// Ports: d_i/c_i per-branch sample/coef, sum_o partial sum.
module ppd_branch_sum
  import ppd_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = ppd_pkg::COEF_W,
  parameter int ACC_W  = DATA_W + COEF_W + 5
) (
  input  logic signed [DATA_W-1:0] d_i [NUM_PHASE],
  input  logic signed [COEF_W-1:0] c_i [NUM_PHASE],
  output logic signed [ACC_W-1:0]  sum_o
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod [NUM_PHASE];

  always_comb begin
    sum_o = '0;
    for (int p = 0; p < NUM_PHASE; p++) begin
      prod[p] = PW'(d_i[p]) * PW'(c_i[p]);
      sum_o   = sum_o + ACC_W'(prod[p]);
    end
  end

endmodule

// File: rtl/ppd_poly_mac.sv
// Polyphase decimator MAC: 5-frame delay line, one coef group
// per cycle, result after 6 cycles. Ports: clk_i, rst_i (sync,
// active-high), bus (ppd_poly_mac_if.slave), start_o/change_o
// to the coef source, coef_p1_i..coef_p4_i from it.
// Macro PPD_MAC_ROUND_EN: rounded, saturated DATA_W output.
module ppd_poly_mac
  import ppd_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int COEF_W    = ppd_pkg::COEF_W,
  parameter int ACC_W     = DATA_W + COEF_W + 5,
  parameter int OUT_SHIFT = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ppd_poly_mac_if.slave            bus,
  output logic                     start_o,
  output logic                     change_o,
  input  logic signed [COEF_W-1:0] coef_p1_i,
  input  logic signed [COEF_W-1:0] coef_p2_i,
  input  logic signed [COEF_W-1:0] coef_p3_i,
  input  logic signed [COEF_W-1:0] coef_p4_i
);

`ifdef PPD_MAC_ROUND_EN
  localparam int OUT_W = DATA_W;
`else
  localparam int OUT_W = ACC_W;
`endif

  localparam logic [GRP_W-1:0] K_LAST =
    GRP_W'(NUM_GROUP - 1);

  state_e state_q;
  state_e state_d;

  logic [GRP_W-1:0] k_q;
  logic [GRP_W-1:0] k_d;

  logic signed [DATA_W-1:0] d_q [NUM_GROUP][NUM_PHASE];
  logic signed [DATA_W-1:0] din  [NUM_PHASE];
  logic signed [DATA_W-1:0] dsel [NUM_PHASE];
  logic signed [COEF_W-1:0] coef [NUM_PHASE];

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] psum;
  logic signed [OUT_W-1:0] dout_q;
  logic signed [OUT_W-1:0] dout_d;

  logic accept;
  logic in_ready;
  logic out_valid;
  logic start;
  logic change;
  logic last;

  assign din[0] = bus.din_p1_i;
  assign din[1] = bus.din_p2_i;
  assign din[2] = bus.din_p3_i;
  assign din[3] = bus.din_p4_i;

  assign coef[0] = coef_p1_i;
  assign coef[1] = coef_p2_i;
  assign coef[2] = coef_p3_i;
  assign coef[3] = coef_p4_i;

  assign last = (k_q == K_LAST);

  // the group counter picks the delay-line frame that
  // matches the coefficient group on the coef inputs
  always_comb begin
    for (int p = 0; p < NUM_PHASE; p++) begin
      dsel[p] = d_q[k_q][p];
    end
  end

  ppd_branch_sum #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_sum (
    .d_i   (dsel),
    .c_i   (coef),
    .sum_o (psum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    change    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          accept  = 1'b1;
          start   = 1'b1;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d  = (k_q == '0 ? '0 : acc_q) + psum;
        change = !last;
        k_d    = k_q + 1'b1;
        if (last) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // no handshake or coef-source control while in reset
    if (rst_i) begin
      accept   = 1'b0;
      in_ready = 1'b0;
      start    = 1'b0;
      change   = 1'b0;
    end
  end

`ifdef PPD_MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_K =
    ACC_W'(64'sd1 <<< (OUT_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI_A =
    ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO_A =
    ACC_W'(sat_lo(DATA_W));

  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (acc_d + RND_K) >>> OUT_SHIFT;
    if (rnd > SAT_HI_A) begin
      dout_d = SAT_HI_A[OUT_W-1:0];
    end else if (rnd < SAT_LO_A) begin
      dout_d = SAT_LO_A[OUT_W-1:0];
    end else begin
      dout_d = rnd[OUT_W-1:0];
    end
  end
`else
  assign dout_d = acc_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      dout_q <= '0;
      d_q    <= '{default: '0};
    end else begin
      acc_q <= acc_d;
      // result captured on the last MAC cycle, so it is
      // already stable on entry to OUT
      if (state_q == MAC && last) begin
        dout_q <= dout_d;
      end
      if (accept) begin
        for (int k = NUM_GROUP - 1; k > 0; k--) begin
          d_q[k] <= d_q[k-1];
        end
        d_q[0] <= din;
      end
    end
  end

  // the rounding shift must leave integer bits behind
  shift_fits_acc: assert property (
    @(posedge clk_i) (OUT_SHIFT > 0) && (OUT_SHIFT < ACC_W)
  );

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.dout_o      = dout_q;
  assign start_o         = start;
  assign change_o        = change;

endmodule

// File: tb/tb_ppd_poly_mac.sv
// Bench for ppd_poly_mac: coef-source model, delay-line
// reference model, directed and random frames.
module tb_ppd_poly_mac;

  localparam int DATA_W    = 12;
  localparam int COEF_W    = 11;
  localparam int ACC_W     = 28;
  localparam int OUT_SHIFT = 10;

  typedef logic signed [63:0] val_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start;
  logic change;
  logic signed [COEF_W-1:0] c1, c2, c3, c4;

  ppd_poly_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) ifc ();

  ppd_poly_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (ifc),
    .start_o   (start),
    .change_o  (change),
    .coef_p1_i (c1),
    .coef_p2_i (c2),
    .coef_p3_i (c3),
    .coef_p4_i (c4)
  );

  always #5 clk = ~clk;

  int h [20];
  int dl [5][4];
  int grp = 0;
  int g;
  int pass_cnt  = 0;
  int total_cnt = 0;

  // coefficient source: start -> group 0, change -> next
  always @(posedge clk) begin
    if (start) grp <= 0;
    else if (change) grp <= grp + 1;
  end

  always_comb begin
    g  = (grp > 4) ? 4 : grp;
    c1 = h[4*g+0][COEF_W-1:0];
    c2 = h[4*g+1][COEF_W-1:0];
    c3 = h[4*g+2][COEF_W-1:0];
    c4 = h[4*g+3][COEF_W-1:0];
  end

  task automatic check(input string tag, input val_t obs,
                       input val_t exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  function automatic val_t model_y();
    longint y = 0;
    for (int k = 0; k < 5; k++)
      for (int p = 0; p < 4; p++)
        y += longint'(h[4*k+p]) * longint'(dl[k][p]);
`ifdef PPD_MAC_ROUND_EN
    y = (y + (64'sd1 <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (y > 2047) y = 2047;
    if (y < -2048) y = -2048;
`endif
    return y;
  endfunction

  function automatic val_t dout_s();
    return 64'($signed(ifc.dout_o));
  endfunction

  function automatic int rnd_s(input int half);
    return int'($urandom_range(2 * half - 1)) - half;
  endfunction

  // caller sits 1 time unit after a falling edge
  task automatic run_frame(input int a, input int b,
                           input int c, input int e,
                           input int stall,
                           output val_t res);
    int n;
    int lat;
    int st;
    int ch;
    int both;
    val_t exp;
    val_t held;
    ifc.in_valid_i = 1'b1;
    ifc.din_p1_i = DATA_W'(a);
    ifc.din_p2_i = DATA_W'(b);
    ifc.din_p3_i = DATA_W'(c);
    ifc.din_p4_i = DATA_W'(e);
    #1;
    n = 0;
    while (ifc.in_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("accept_ready", 64'(ifc.in_ready_o), 1);
    check("start_on_accept", 64'(start), 1);
    check("no_change_on_accept", 64'(change), 0);
    for (int k = 4; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = '{a, b, c, e};
    exp = model_y();
    @(negedge clk);
    ifc.in_valid_i = 1'b0;
    #1;
    lat = 1; st = 0; ch = 0; both = 0;
    while (ifc.out_valid_o !== 1'b1 && lat < 20) begin
      st += int'(start);
      ch += int'(change);
      both += int'(start & change);
      @(negedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 6);
    check("extra_start", 64'(st), 0);
    check("change_pulses", 64'(ch), 4);
    check("start_change_overlap", 64'(both), 0);
    check("result", dout_s(), exp);
    res = dout_s();
    held = dout_s();
    for (int i = 0; i < stall; i++) begin
      ifc.out_ready_i = 1'b0;
      ifc.in_valid_i = 1'b1;
      ifc.din_p1_i = DATA_W'(rnd_s(2048));
      ifc.din_p2_i = DATA_W'(rnd_s(2048));
      @(negedge clk); #1;
      check("bp_valid_held", 64'(ifc.out_valid_o), 1);
      check("bp_not_ready", 64'(ifc.in_ready_o), 0);
      check("bp_no_start", 64'(start), 0);
      check("bp_dout_held", dout_s(), held);
    end
    ifc.in_valid_i = 1'b0;
    ifc.out_ready_i = 1'b1;
    @(negedge clk); #1;
    ifc.out_ready_i = 1'b0;
    check("idle_ready", 64'(ifc.in_ready_o), 1);
    check("idle_valid", 64'(ifc.out_valid_o), 0);
  endtask

  task automatic impulse(input string tag);
    val_t r;
    val_t imp [5];
`ifdef PPD_MAC_ROUND_EN
    imp = '{0, -2, 18, 10, -1};
`else
    imp = '{300, -2300, 18900, 10200, -1300};
`endif
    for (int i = 0; i < 5; i++) begin
      if (i == 0) run_frame(100, 0, 0, 0, 0, r);
      else run_frame(0, 0, 0, 0, 0, r);
      check(tag, r, imp[i]);
    end
  endtask

  initial begin
    val_t r;
    int real_h [10];
    real_h = '{3, 2, -3, -13, -23, -16, 26, 102, 189, 247};
    for (int i = 0; i < 10; i++) begin
      h[i] = real_h[i];
      h[19-i] = real_h[i];
    end
    dl = '{default: 0};
    ifc.in_valid_i = 1'b0;
    ifc.out_ready_i = 1'b0;
    ifc.din_p1_i = '0;
    ifc.din_p2_i = '0;
    ifc.din_p3_i = '0;
    ifc.din_p4_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(ifc.in_ready_o), 1);
    check("rst_valid", 64'(ifc.out_valid_o), 0);
    check("rst_dout", dout_s(), 0);
    check("rst_start", 64'(start), 0);
    check("rst_change", 64'(change), 0);

    impulse("impulse");

    for (int i = 0; i < 5; i++) run_frame(1, 1, 1, 1, 0, r);
`ifdef PPD_MAC_ROUND_EN
    check("dc", r, 1);
`else
    check("dc", r, 1028);
`endif

    for (int i = 0; i < 5; i++)
      run_frame(2047, 2047, 2047, 2047, (i == 4) ? 3 : 0, r);
`ifdef PPD_MAC_ROUND_EN
    check("saturation", r, 2047);
`else
    check("saturation", r, 2104316);
`endif
    // only the frame after the stall may enter the line
    run_frame(-5, 7, 300, -2048, 0, r);

    // reset during MAC group 2
    ifc.in_valid_i = 1'b1;
    ifc.din_p1_i = DATA_W'(100);
    ifc.din_p2_i = '0;
    ifc.din_p3_i = '0;
    ifc.din_p4_i = '0;
    #1;
    check("mid_accept", 64'(ifc.in_ready_o), 1);
    @(negedge clk);
    ifc.in_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ifc.in_ready_o), 1);
    check("mid_rst_valid", 64'(ifc.out_valid_o), 0);
    check("mid_rst_dout", dout_s(), 0);
    check("mid_rst_change", 64'(change), 0);
    dl = '{default: 0};
    impulse("impulse_after_rst");

    for (int i = 0; i < 20; i++) h[i] = rnd_s(1024);
    for (int i = 0; i < 12; i++)
      run_frame(rnd_s(2048), rnd_s(2048), rnd_s(2048),
                rnd_s(2048), int'($urandom_range(3)), r);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ppd_poly_mac.md
# ppd_poly_mac

Time-multiplexed multiply-accumulate engine for the direct polyphase decimator. It sits directly downstream of the 20-tap polyphase coefficient source and drives that source's `start`/`change` controls. It accepts one 4-sample input frame per handshake, one sample per polyphase branch. For each frame it computes one decimated output by stepping through the 5 coefficient groups, one group per cycle.

## Interface
- `DATA_W`, default 12: signed input sample width.
- `COEF_W`, default 11: signed coefficient width. Must match the coefficient source.
- `ACC_W`, default `DATA_W+COEF_W+5`: accumulator width, 28 at defaults. This covers 20 full-scale products with no overflow.
- `OUT_SHIFT`, default 10: coefficient fractional bits. Used only when `PPD_MAC_ROUND_EN` is defined.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `in_valid_i`, in, 1: input frame valid.
- `in_ready_o`, out, 1: frame accepted when high together with `in_valid_i`.
- `din_p1_i`..`din_p4_i`, in, `DATA_W` each: frame samples for branches 1..4.
- `start_o`, out, 1: coefficient-source `start` (restart at group 0).
- `change_o`, out, 1: coefficient-source `change` (advance one group).
- `coef_p1_i`..`coef_p4_i`, in, `COEF_W` each: current group coefficients for branches 1..4.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: downstream ready.
- `dout_o`, out, `ACC_W` (or `DATA_W` with `PPD_MAC_ROUND_EN`): result.

## Operation
- **Delay line:** `d[0..4][1..4]` holds 5 frames of 4 samples, all signed. `d[0]` is the newest frame.
  - On accept: `d[k] <= d[k-1]` for k=1..4, then `d[0] <= din`.
- **Result:** `y = Σ_{k=0..4} Σ_{p=1..4} h[4k+p-1]·d[k][p]`. Here `h` is the value on `coef_p*_i` while the group counter equals k.
- **FSM states:** `IDLE`, `MAC`, `OUT`.
  - `IDLE`: `in_ready_o=1`. On accept, assert `start_o` combinationally in the same cycle, set k=0, go to `MAC`.
  - `MAC`: runs for k=0..4.
    - Each cycle: `acc <= (k==0 ? 0 : acc) + (c1·d[k][1] + c2·d[k][2] + c3·d[k][3] + c4·d[k][4])`.
    - `change_o=1` for k=0..3 only.
    - After k=4, go to `OUT`.
  - `OUT`: `out_valid_o=1`, `dout_o` is stable. When `out_ready_i=1`, go to `IDLE`.
- `in_ready_o=0` in `MAC` and `OUT`. An `in_valid_i` asserted there is ignored.
- `start_o` and `change_o` are never high in the same cycle.
- **Arithmetic:** full-precision signed products, sign-extended to `ACC_W` before summing. No wrap can occur at the defaults.
- **Reset** (any state, including mid-`MAC`) clears the following, and the state returns to `IDLE`:
  - the delay line;
  - `acc`;
  - `out_valid_o=0`, `dout_o=0`, `start_o=0`, `change_o=0`, `in_ready_o=1`.
- The next accept pulses `start_o`, which realigns the coefficient source whatever its count was.

## Timing
- **Accept at cycle t:** `start_o` is high in t. The coefficient source presents group 0 at t+1.
- **MAC cycles:** group k is present at t+1+k, so MAC runs t+1..t+5.
- **Result:** `out_valid_o` rises at t+6. Latency from accept to valid is 6 cycles.
- **Peak rate:** one frame per 7 cycles, when `out_ready_i` is high at t+6.
- **Backpressure:** `out_valid_o` and `dout_o` are held indefinitely while `out_ready_i=0`.

## Configuration
- `PPD_MAC_ROUND_EN` defined:
  - `dout_o` is `DATA_W` wide and is computed as `(acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT` (round half up).
  - The result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - It is registered on entry to `OUT`, with no added latency.
- Undefined: `dout_o` is the full `ACC_W`-bit accumulator.

## Structure
- **Shared package `ppd_pkg`:**
  - `NUM_PHASE=4`, `NUM_GROUP=5`, `COEF_W=11`;
  - the FSM state enum;
  - the saturation bounds.
- **Sub-module `ppd_branch_sum`:** combinational; 4 signed multipliers plus the adder tree producing one group partial sum. Instantiated once.

## Test plan
- **Impulse:**
  - Stimulus: reset, then frame (100,0,0,0), then 4 zero frames, with real coefficients h0..h19 = 3,2,-3,-13,-23,-16,26,102,189,247 mirrored.
  - Required results (macro undefined): 300, -2300, 18900, 10200, -1300.
- **DC:**
  - Stimulus: 5 frames of all 1s.
  - Required: 5th result 1028. With macro: 1.
- **Saturation:**
  - Stimulus: 5 frames of all 2047.
  - Required: undefined gives 2104316; `PPD_MAC_ROUND_EN` gives 2047.
- **Backpressure:**
  - Stimulus: hold `out_ready_i=0` for 3 cycles after valid, while driving `in_valid_i=1`.
  - Required: `out_valid_o` held, `in_ready_o=0`, no frame accepted, delay line unchanged. The next accept occurs 1 cycle after `out_ready_i` rises.
- **Control sequencing:**
  - Required: every accept produces exactly 1 `start_o` followed by 4 `change_o` pulses. Never both in one cycle.
- **Reset mid-MAC:**
  - Stimulus: assert `rst_i` at MAC k=2.
  - Required: next cycle is `IDLE` with `out_valid_o=0`. Feeding the impulse sequence again reproduces exactly the impulse results.
